// File: rtl/aes_byte_stream.sv
// Byte-serial wrapper around the aes core: gathers key and plaintext bytes,
// triggers the core, then streams the ciphertext back out MSB byte first.
//
// state | meaning
// LOAD  | accepting the 32-byte frame (key then plaintext)
// START | frame complete, waiting for an idle core to trigger
// ACK   | trigger issued, waiting for the core to drop done
// RUN   | core busy, waiting for done to capture ciphertext
// SEND  | streaming 16 ciphertext bytes
module aes_byte_stream #(
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [7:0]   m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] aes_key,
  output logic [127:0] aes_plaintext,
  output logic         aes_trigger,
  input  logic         aes_done,
  input  logic [127:0] aes_ciphertext,
  output logic         busy,
  output logic         timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    START = 3'd1,
    ACK   = 3'd2,
    RUN   = 3'd3,
    SEND  = 3'd4
  } state_t;

  state_t         state;
  logic [255:0]   in_sr;
  logic [127:0]   out_sr;
  logic [4:0]     in_cnt;
  logic [3:0]     out_cnt;
  logic [TW-1:0]  t_cnt;

  assign s_ready       = (state == LOAD);
  assign aes_key       = in_sr[255:128];
  assign aes_plaintext = in_sr[127:0];
  assign m_data        = out_sr[127:120];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= LOAD;
      in_sr       <= '0;
      out_sr      <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      t_cnt       <= '0;
      aes_trigger <= 1'b0;
      m_valid     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      aes_trigger <= 1'b0;
      case (state)
        LOAD: begin
          if (s_valid) begin
            in_sr       <= {in_sr[247:0], s_data};
            in_cnt      <= in_cnt + 5'd1;
            timeout_err <= 1'b0;
            if (in_cnt == 5'd31) begin
              state <= START;
              busy  <= 1'b1;
            end
          end
        end
        START: begin
          if (aes_done) begin
            aes_trigger <= 1'b1;
            t_cnt       <= '0;
            state       <= ACK;
          end
        end
        ACK, RUN: begin
          t_cnt <= t_cnt + 1'b1;
          // progress wins over the timeout if both land on the same cycle
          if (state == ACK && !aes_done) begin
            state <= RUN;
          end else if (state == RUN && aes_done) begin
            out_sr  <= aes_ciphertext;
            out_cnt <= '0;
            m_valid <= 1'b1;
            state   <= SEND;
          end else if (t_cnt == TLAST) begin
            state       <= LOAD;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            in_cnt      <= '0;
            out_cnt     <= '0;
          end
        end
        SEND: begin
          if (m_ready) begin
            out_sr  <= {out_sr[119:0], 8'h00};
            out_cnt <= out_cnt + 4'd1;
            if (out_cnt == 4'd15) begin
              m_valid <= 1'b0;
              busy    <= 1'b0;
              in_cnt  <= '0;
              state   <= LOAD;
            end
          end
        end
        default: begin
          state   <= LOAD;
          busy    <= 1'b0;
          m_valid <= 1'b0;
          in_cnt  <= '0;
          out_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_byte_stream.md
# aes_byte_stream

Byte-serial front/back end for the `aes` core: collects a 16-byte key and a 16-byte plaintext over a valid/ready byte stream and presents them as 128-bit words. It pulses the core's trigger, waits for the core's completion, captures the ciphertext and returns it as 16 bytes on a second valid/ready stream. It sits directly between the I/O layer (UART/FIFO) and the `aes` core's `key`, `plaintext`, `trigger`, `done` and `ciphertext` pins.

## Interface
- `TIMEOUT`, 4096: maximum cycles allowed in ACK plus RUN before the frame is aborted; must be ≥ 2.
- `clk` in 1: single clock.
- `reset_n` in 1: reset is asynchronous and active-low.
- `s_data` in 8: input byte.
- `s_valid` in 1: input byte valid.
- `s_ready` out 1: block accepts input byte.
- `m_data` out 8: ciphertext byte.
- `m_valid` out 1: output byte valid.
- `m_ready` in 1: consumer accepts output byte.
- `aes_key` out 128: to core `key`; held stable from START until return to LOAD.
- `aes_plaintext` out 128: to core `plaintext`; held stable likewise.
- `aes_trigger` out 1: to core `trigger`; single-cycle pulse.
- `aes_done` in 1: from core `done`; high when the core is idle.
- `aes_ciphertext` in 128: from core `ciphertext`.
- `busy` out 1: high in every state except LOAD.
- `timeout_err` out 1: sticky; set on abort, cleared on the first accepted byte of the next frame.

## Operation
- Frame: 32 input bytes. Bytes 0–15 form the key and bytes 16–31 form the plaintext. Byte 0 maps to bits [127:120] (MSB first); each accepted byte shifts into the LSB end of a 256-bit shift register. Output bytes are sent in the same order: ciphertext[127:120] first.
- Counters: 5-bit input count (0–31) and 4-bit output count (0–15). Both clear on entry to LOAD. No wrap is visible, because the state changes at terminal count.
- A timeout counter is cleared on entry to ACK and increments each cycle in ACK and RUN.
- State machine:
  - LOAD: `s_ready`=1. A byte is accepted on `s_valid && s_ready`. The 32nd accepted byte moves the FSM to START.
  - START: `s_ready`=0. Wait while `aes_done`=0 (core still busy). When `aes_done`=1, drive `aes_trigger`=1 for exactly that cycle and move to ACK.
  - ACK: wait for `aes_done`=0. The core's done deasserts two cycles after trigger, so `aes_done` high in ACK is never taken as completion. On `aes_done`=0, move to RUN.
  - RUN: on `aes_done`=1, register `aes_ciphertext` into the output shift register and move to SEND.
  - SEND: `m_valid`=1 and `m_data` = the current top byte. Shift on `m_valid && m_ready`. The 16th handshake moves the FSM to LOAD.
  - Timeout: if the timeout counter reaches `TIMEOUT` in ACK or RUN, go to LOAD, set `timeout_err`=1 and produce no output bytes.
  - Unused state encodings go to LOAD.
- `s_valid` is ignored outside LOAD. `m_ready` is ignored outside SEND.
- Reset (any time, including mid-frame or mid-SEND): go to LOAD immediately. Partial input is discarded and no further output bytes are produced.
- Reset values: state LOAD, `s_ready`=1, `m_valid`=0, `m_data`=0, `aes_trigger`=0, `aes_key`=0, `aes_plaintext`=0, `busy`=0, `timeout_err`=0, all counters 0.

## Timing
- `aes_trigger`, `m_valid`, `m_data`, `busy` and `timeout_err` are registered outputs. `s_ready` decodes from the state register only, with no combinational path from any input.
- One input byte per cycle is sustained. START is entered on the edge that accepts byte 31.
- If `aes_done`=1, `aes_trigger` rises the cycle after byte 31 is accepted.
- Ciphertext is captured on the edge where RUN sees `aes_done`=1. `m_valid` is high from the next cycle.
- Under `m_ready`=1, 16 bytes go out in 16 consecutive cycles. `s_ready` returns to 1 the cycle after the 16th handshake.
- While `m_valid`=1 and `m_ready`=0, `m_data` is held.

## Test plan
- FIPS-197 vector with the real `aes` core: key 000102…0f, plaintext 00112233445566778899aabbccddeeff, bytes streamed back to back -> output bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a in order, exactly one `aes_trigger` pulse, `timeout_err`=0.
- Random `s_valid` gaps plus `m_ready` low for 5 cycles at output byte 3 -> same 16 bytes, `m_data` stable during the stall, no byte dropped or duplicated.
- Core model holds `aes_done`=0 for 10 cycles after byte 31 -> `aes_trigger` stays 0 until `aes_done` rises, then pulses once.
- Core model never raises done, with `TIMEOUT`=16 -> return to LOAD 16 cycles after ACK entry, `timeout_err`=1, `m_valid` never 1. The next accepted byte clears `timeout_err`.
- `reset_n` low after byte 20, then a fresh 32-byte frame -> the output matches the fresh frame only, and all outputs hold their reset values while `reset_n`=0.
- `reset_n` low after output byte 7 -> `m_valid` drops asynchronously and stays 0, `s_ready`=1.
